// File: rtl/capture_sequencer.sv
// Logic-analyzer capture sequencer: arms the engine, fills a circular sample RAM.
// Optional trigger timeout is compiled in with CAPSEQ_TIMEOUT_EN.
module capture_sequencer #(
  parameter int DSIZE = 32,
  parameter int AW    = 24,
  parameter int TO_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort_req,
  input  logic [AW-1:0]    buffer_size,
  input  logic [AW-1:0]    post_count,
  input  logic [TO_W-1:0]  timeout,
  output logic             cap_arm,
  output logic             cap_abort,
  input  logic             cap_armed,
  input  logic             cap_trig,
  input  logic             cap_overrun,
  input  logic [DSIZE-1:0] s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [DSIZE-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             overrun_err,
  output logic             timed_out,
  output logic [AW-1:0]    trig_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_PRE,
    S_POST,
    S_DONE,
    S_ABORT
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0]    bsize_q, bsize_d;
  logic [AW-1:0]    post_q, post_d;
  logic [AW-1:0]    post_cnt_q, post_cnt_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [AW-1:0]    trig_addr_q, trig_addr_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [DSIZE-1:0] wr_data_q, wr_data_d;
  logic             wr_en_q, wr_en_d;
  logic             s_tready_q, s_tready_d;
  logic             aborted_q, aborted_d;
  logic             ovr_q, ovr_d;
  logic             to_flag_q, to_flag_d;

  logic             beat;
  logic             do_wr;
  logic             to_hit;
  logic [AW-1:0]    ptr_inc;
  logic [AW-1:0]    post_inc;

  assign beat     = s_tvalid && s_tready_q;
  assign ptr_inc  = (ptr_q == bsize_q - AW'(1)) ? '0 : ptr_q + AW'(1);
  assign post_inc = post_cnt_q + AW'(1);

`ifdef CAPSEQ_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Held at zero while arming so the count starts fresh on PRE entry.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == S_ARM)
      to_cnt_d = '0;
    else if (state_q == S_PRE)
      to_cnt_d = to_cnt_q + TO_W'(1);
  end

  assign to_hit = (state_q == S_PRE) && (timeout != '0) &&
                  (to_cnt_q + TO_W'(1) == timeout);

  always_ff @(posedge clk) begin
    if (reset)
      to_cnt_q <= '0;
    else
      to_cnt_q <= to_cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout;
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    bsize_d     = bsize_q;
    post_d      = post_q;
    post_cnt_d  = post_cnt_q;
    ptr_d       = ptr_q;
    trig_addr_d = trig_addr_q;
    aborted_d   = aborted_q;
    ovr_d       = ovr_q;
    to_flag_d   = to_flag_q;
    do_wr       = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start && !abort_req) begin
          state_d    = S_ARM;
          bsize_d    = buffer_size;
          post_d     = post_count;
          post_cnt_d = '0;
          ptr_d      = '0;
          aborted_d  = 1'b0;
          ovr_d      = 1'b0;
          to_flag_d  = 1'b0;
        end
      end
      S_ARM: begin
        if (abort_req) begin
          state_d   = S_ABORT;
          aborted_d = 1'b1;
        end else if (cap_armed) begin
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        if (abort_req) begin
          state_d   = S_ABORT;
          aborted_d = 1'b1;
        end else if (cap_trig) begin
          trig_addr_d = ptr_q;
          post_cnt_d  = '0;
          if (post_q == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_POST;
            // Trigger-cycle beat is the first post-trigger sample.
            if (beat) begin
              do_wr      = 1'b1;
              ptr_d      = ptr_inc;
              post_cnt_d = AW'(1);
              if (post_q == AW'(1))
                state_d = S_DONE;
            end
          end
        end else if (to_hit) begin
          state_d   = S_ABORT;
          aborted_d = 1'b1;
          to_flag_d = 1'b1;
        end else if (beat) begin
          do_wr = 1'b1;
          ptr_d = ptr_inc;
        end
      end
      S_POST: begin
        if (abort_req) begin
          state_d   = S_ABORT;
          aborted_d = 1'b1;
        end else if (beat) begin
          do_wr      = 1'b1;
          ptr_d      = ptr_inc;
          post_cnt_d = post_inc;
          if (post_inc == post_q)
            state_d = S_DONE;
        end
      end
      S_ABORT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if ((state_q == S_PRE || state_q == S_POST) && cap_overrun)
      ovr_d = 1'b1;
  end

  // Between writes the address port shows the next slot to be written.
  assign wr_en_d    = do_wr;
  assign wr_addr_d  = do_wr ? ptr_q : ptr_d;
  assign wr_data_d  = do_wr ? s_tdata : wr_data_q;
  assign s_tready_d = (state_d != S_ARM);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bsize_q     <= '0;
      post_q      <= '0;
      post_cnt_q  <= '0;
      ptr_q       <= '0;
      trig_addr_q <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      s_tready_q  <= 1'b0;
      aborted_q   <= 1'b0;
      ovr_q       <= 1'b0;
      to_flag_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bsize_q     <= bsize_d;
      post_q      <= post_d;
      post_cnt_q  <= post_cnt_d;
      ptr_q       <= ptr_d;
      trig_addr_q <= trig_addr_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      s_tready_q  <= s_tready_d;
      aborted_q   <= aborted_d;
      ovr_q       <= ovr_d;
      to_flag_q   <= to_flag_d;
    end
  end

  assign cap_arm     = (state_q == S_ARM);
  assign cap_abort   = (state_q == S_ABORT);
  assign busy        = (state_q == S_ARM) || (state_q == S_PRE) ||
                       (state_q == S_POST) || (state_q == S_ABORT);
  assign done        = (state_q == S_DONE);
  assign s_tready    = s_tready_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign aborted     = aborted_q;
  assign overrun_err = ovr_q;
  assign timed_out   = to_flag_q;
  assign trig_addr   = trig_addr_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Scoreboard bench for capture_sequencer: expected RAM writes queued at drive
// time, popped when wr_en appears.
module tb_capture_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort_req;
  logic [23:0] buffer_size, post_count;
  logic [31:0] timeout;
  logic        cap_arm, cap_abort, cap_armed, cap_trig, cap_overrun;
  logic [31:0] s_tdata;
  logic        s_tvalid, s_tready;
  logic        wr_en;
  logic [23:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy, done, aborted, overrun_err, timed_out;
  logic [23:0] trig_addr;

  typedef struct packed {
    logic [23:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [23:0] mptr;
  int          mbs;
  logic [23:0] exp_trig;
  int          n_chk = 0;
  int          n_err = 0;
  int          n_abort = 0;
  int          exp_abort = 0;

  always #5 clk = ~clk;

  capture_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort_req(abort_req),
    .buffer_size(buffer_size), .post_count(post_count), .timeout(timeout),
    .cap_arm(cap_arm), .cap_abort(cap_abort), .cap_armed(cap_armed),
    .cap_trig(cap_trig), .cap_overrun(cap_overrun),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .aborted(aborted),
    .overrun_err(overrun_err), .timed_out(timed_out),
    .trig_addr(trig_addr)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cap_abort) n_abort++;
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        chk("wr_en_spurious", 64'(wr_en), 64'(0));
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 64'(wr_addr), 64'(mon_e.a));
        chk("wr_data", 64'(wr_data), 64'(mon_e.d));
      end
    end
  end

  task automatic idle();
    s_tvalid    = 1'b0;
    cap_trig    = 1'b0;
    abort_req   = 1'b0;
    cap_overrun = 1'b0;
    @(negedge clk);
  endtask

  task automatic beat(input bit trig, input bit wr);
    s_tvalid = 1'b1;
    s_tdata  = $urandom;
    cap_trig = trig;
    if (wr) begin
      exp_q.push_back(wr_t'{a: mptr, d: s_tdata});
      mptr = (mptr == 24'(mbs - 1)) ? 24'd0 : mptr + 24'd1;
    end
    @(negedge clk);
  endtask

  task automatic start_cap(input int bs, input int pc);
    buffer_size = 24'(bs);
    post_count  = 24'(pc);
    cap_armed   = 1'b0;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mptr  = '0;
    mbs   = bs;
    chk("cap_arm", 64'(cap_arm), 64'(1));
    chk("aborted_clr", 64'(aborted), 64'(0));
    chk("overrun_clr", 64'(overrun_err), 64'(0));
    cap_armed = 1'b1;
    @(negedge clk);
    chk("pre_ready", 64'(s_tready), 64'(1));
  endtask

  initial begin
    reset = 1'b1; start = 0; abort_req = 0; buffer_size = 0;
    post_count = 0; timeout = 0; cap_armed = 0; cap_trig = 0;
    cap_overrun = 0; s_tdata = 0; s_tvalid = 0;
    mptr = 0; mbs = 1; exp_trig = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_arm", 64'(cap_arm), 64'(0));
    chk("rst_wr_en", 64'(wr_en), 64'(0));
    chk("rst_ready", 64'(s_tready), 64'(0));
    chk("rst_trig_addr", 64'(trig_addr), 64'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", 64'(s_tready), 64'(1));

    // Wrapping capture, trigger on the 11th sample
    start_cap(8, 3);
    repeat (10) beat(0, 1);
    exp_trig = mptr;
    repeat (3) beat(1, 1);
    idle();
    chk("t1_done", 64'(done), 64'(1));
    chk("t1_busy", 64'(busy), 64'(0));
    repeat (3) beat(1, 0);
    idle();
    chk("t1_trig_addr", 64'(trig_addr), 64'(exp_trig));
    chk("t1_trig_is_2", 64'(trig_addr), 64'(2));
    chk("t1_wr_addr", 64'(wr_addr), 64'(mptr));

    // Zero post-trigger samples
    start_cap(8, 0);
    repeat (4) beat(0, 1);
    exp_trig = mptr;
    beat(1, 0);
    chk("t2_done", 64'(done), 64'(1));
    chk("t2_trig_addr", 64'(trig_addr), 64'(exp_trig));
    repeat (2) beat(0, 0);
    idle();
    chk("t2_wr_addr", 64'(wr_addr), 64'(mptr));

    // Abort during POST
    start_cap(16, 5);
    repeat (3) beat(0, 1);
    repeat (2) beat(1, 1);
    abort_req = 1'b1;
    beat(1, 0);
    abort_req = 1'b0;
    exp_abort++;
    chk("t3_cap_abort", 64'(cap_abort), 64'(1));
    chk("t3_aborted", 64'(aborted), 64'(1));
    idle();
    chk("t3_cap_abort_end", 64'(cap_abort), 64'(0));
    chk("t3_busy", 64'(busy), 64'(0));
    repeat (2) beat(0, 0);
    idle();
    chk("t3_abort_pulses", 64'(n_abort), 64'(exp_abort));

    // start and abort_req together from IDLE
    start = 1'b1;
    abort_req = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort_req = 1'b0;
    chk("t4_busy", 64'(busy), 64'(0));
    chk("t4_arm", 64'(cap_arm), 64'(0));
    chk("t4_aborted_kept", 64'(aborted), 64'(1));
    idle();
    chk("t4_arm_late", 64'(cap_arm), 64'(0));

    // Overrun in PRE is sticky, capture still completes
    start_cap(8, 2);
    repeat (2) beat(0, 1);
    cap_overrun = 1'b1;
    beat(0, 1);
    cap_overrun = 1'b0;
    beat(0, 1);
    chk("t5_overrun", 64'(overrun_err), 64'(1));
    repeat (2) beat(1, 1);
    idle();
    chk("t5_done", 64'(done), 64'(1));
    chk("t5_overrun_held", 64'(overrun_err), 64'(1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t5_overrun_clr", 64'(overrun_err), 64'(0));
    chk("t5_done_clr", 64'(done), 64'(0));
    abort_req = 1'b1;
    @(negedge clk);
    abort_req = 1'b0;
    exp_abort++;
    chk("t5_arm_abort", 64'(cap_abort), 64'(1));
    idle();

    // Reset mid-capture: no abort pulse, outputs cleared
    start_cap(8, 2);
    repeat (3) beat(0, 1);
    reset = 1'b1;
    s_tvalid = 1'b1;
    @(negedge clk);
    s_tvalid = 1'b0;
    @(negedge clk);
    chk("t6_busy", 64'(busy), 64'(0));
    chk("t6_wr_en", 64'(wr_en), 64'(0));
    chk("t6_ready", 64'(s_tready), 64'(0));
    reset = 1'b0;
    idle();
    chk("t6_abort_pulses", 64'(n_abort), 64'(exp_abort));

`ifdef CAPSEQ_TIMEOUT_EN
    begin
      int n;
      timeout = 32'd50;
      start_cap(8, 1);
      n = 1;
      for (int i = 0; i < 200; i++) begin
        idle();
        if (cap_abort) break;
        n++;
      end
      chk("to_pre_cycles", 64'(n), 64'(50));
      chk("to_timed_out", 64'(timed_out), 64'(1));
      chk("to_aborted", 64'(aborted), 64'(1));
      timeout = 32'd0;
      idle();
    end
`endif

    repeat (2) idle();
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
